pp_reduce_pipe_18x18: RTL and testbench

//  Downstream stage of the radix-4 Booth encoder in the 18x18 multiplier.
//  - Takes the ten 20-bit Booth partial products and reduces them with a carry-save (3:2) tree.
//  - A final carry-propagate add produces the 36-bit product, signed or unsigned per the encoder's modes.
//  - Three pipeline stages with valid tracking and a clock-enable stall.

---
 rtl/pp_reduce_pipe_18x18_pkg.sv | 22 ++
 rtl/pp_reduce_pipe_18x18_if.sv | 38 +++
 rtl/pp_reduce_pipe_18x18_csa32.sv | 18 +
 rtl/pp_reduce_pipe_18x18.sv | 107 ++++++++++
 tb/tb_pp_reduce_pipe_18x18.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/pp_reduce_pipe_18x18_pkg.sv
// Shared arithmetic constants and helpers for the 18x18 radix-4 Booth multiplier.
//   PP_W     width of each Booth partial product (two's complement)
//   NUM_PP   number of partial products; pp k carries weight 4^k
//   PROD_W   product width; all reduction arithmetic is modulo 2^PROD_W
//   PIPE_LAT enabled-cycle latency of the reduction pipeline
package mult_pkg;

  localparam int unsigned PP_W     = 20;
  localparam int unsigned NUM_PP   = 10;
  localparam int unsigned PROD_W   = 36;
  localparam int unsigned PIPE_LAT = 3;

  // Sign-extend a partial product to PROD_W bits and place it at weight 4^k.
  // Bits shifted above PROD_W-1 fall off, which keeps the sum exact mod 2^PROD_W.
  function automatic logic [PROD_W-1:0] pp_align(input logic [PP_W-1:0] pp,
                                                 input int unsigned    k);
    logic [PROD_W-1:0] ext;
    ext = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp};
    return ext << (2 * k);
  endfunction

endpackage

// File: rtl/pp_reduce_pipe_18x18_if.sv
// Bus between the Booth encoder and the partial-product reduction pipeline.
//   i_ce          pipeline enable (0 freezes every stage)
//   i_valid       partial products valid this cycle
//   i_pp1..i_pp10 partial products, i_pp1 = weight 4^0 ... i_pp10 = weight 4^9
//   o_valid       o_product is valid
//   o_product     36-bit product (two's complement when either operand signed)
// master: the source side (encoder / bench); slave: the reduction pipeline.
interface pp_reduce_pipe_18x18_if;
  import mult_pkg::*;

  logic              i_ce;
  logic              i_valid;
  logic [PP_W-1:0]   i_pp1;
  logic [PP_W-1:0]   i_pp2;
  logic [PP_W-1:0]   i_pp3;
  logic [PP_W-1:0]   i_pp4;
  logic [PP_W-1:0]   i_pp5;
  logic [PP_W-1:0]   i_pp6;
  logic [PP_W-1:0]   i_pp7;
  logic [PP_W-1:0]   i_pp8;
  logic [PP_W-1:0]   i_pp9;
  logic [PP_W-1:0]   i_pp10;
  logic              o_valid;
  logic [PROD_W-1:0] o_product;

  modport master (
    output i_ce, i_valid,
    output i_pp1, i_pp2, i_pp3, i_pp4, i_pp5, i_pp6, i_pp7, i_pp8, i_pp9, i_pp10,
    input  o_valid, o_product
  );

  modport slave (
    input  i_ce, i_valid,
    input  i_pp1, i_pp2, i_pp3, i_pp4, i_pp5, i_pp6, i_pp7, i_pp8, i_pp9, i_pp10,
    output o_valid, o_product
  );

endinterface

// File: rtl/pp_reduce_pipe_18x18_csa32.sv
// 3:2 carry-save adder, purely combinational.
//   a, b, c  three W-bit addends
//   sum      bitwise a^b^c
//   carry    majority(a,b,c) shifted left by one; the carry out of bit W-1 is dropped
module mult_csa32 #(
  parameter int unsigned W = 36
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/pp_reduce_pipe_18x18.sv
// Three-stage reduction of ten radix-4 Booth partial products into a 36-bit product.
//   i_clk   clock, rising edge
//   i_rst   asynchronous, active-high reset; clears valids and all data registers
//   bus     slave side of pp_reduce_pipe_18x18_if (i_ce, i_valid, i_pp1..10 in;
//           o_valid, o_product out)
// S1: align + three CSA levels (10 -> 4 vectors); S2: two CSA levels (4 -> 2);
// S3: carry-propagate add. Every register, valids included, loads only when i_ce=1.
module pp_reduce_pipe_18x18
  import mult_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  pp_reduce_pipe_18x18_if.slave  bus
);

  logic [PP_W-1:0]   pp_in [NUM_PP];
  logic [PROD_W-1:0] t     [NUM_PP];

  always_comb begin
    pp_in[0] = bus.i_pp1;
    pp_in[1] = bus.i_pp2;
    pp_in[2] = bus.i_pp3;
    pp_in[3] = bus.i_pp4;
    pp_in[4] = bus.i_pp5;
    pp_in[5] = bus.i_pp6;
    pp_in[6] = bus.i_pp7;
    pp_in[7] = bus.i_pp8;
    pp_in[8] = bus.i_pp9;
    pp_in[9] = bus.i_pp10;
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_PP; k++) begin
      t[k] = pp_align(pp_in[k], k);
    end
  end

  // S1 tree: 10 -> 7 -> 5 -> 4 (t[9] bypasses all three levels)
  logic [PROD_W-1:0] a0s, a0c, a1s, a1c, a2s, a2c;
  logic [PROD_W-1:0] b0s, b0c, b1s, b1c;
  logic [PROD_W-1:0] c0s, c0c;

  mult_csa32 #(.W(PROD_W)) u_l1_0 (.a(t[0]), .b(t[1]), .c(t[2]), .sum(a0s), .carry(a0c));
  mult_csa32 #(.W(PROD_W)) u_l1_1 (.a(t[3]), .b(t[4]), .c(t[5]), .sum(a1s), .carry(a1c));
  mult_csa32 #(.W(PROD_W)) u_l1_2 (.a(t[6]), .b(t[7]), .c(t[8]), .sum(a2s), .carry(a2c));
  mult_csa32 #(.W(PROD_W)) u_l2_0 (.a(a0s),  .b(a0c),  .c(a1s),  .sum(b0s), .carry(b0c));
  mult_csa32 #(.W(PROD_W)) u_l2_1 (.a(a1c),  .b(a2s),  .c(a2c),  .sum(b1s), .carry(b1c));
  mult_csa32 #(.W(PROD_W)) u_l3_0 (.a(b0s),  .b(b0c),  .c(b1s),  .sum(c0s), .carry(c0c));

  logic [PROD_W-1:0] s1_r0, s1_r1, s1_r2, s1_r3;
  logic              v1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_r0 <= '0;
      s1_r1 <= '0;
      s1_r2 <= '0;
      s1_r3 <= '0;
      v1    <= 1'b0;
    end else if (bus.i_ce) begin
      s1_r0 <= c0s;
      s1_r1 <= c0c;
      s1_r2 <= b1c;
      s1_r3 <= t[9];
      v1    <= bus.i_valid;
    end
  end

  // S2 tree: 4 -> 3 -> 2
  logic [PROD_W-1:0] d0s, d0c, e0s, e0c;

  mult_csa32 #(.W(PROD_W)) u_s2_0 (.a(s1_r0), .b(s1_r1), .c(s1_r2), .sum(d0s), .carry(d0c));
  mult_csa32 #(.W(PROD_W)) u_s2_1 (.a(d0s),   .b(d0c),   .c(s1_r3), .sum(e0s), .carry(e0c));

  logic [PROD_W-1:0] s2_sum, s2_carry;
  logic              v2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_sum   <= '0;
      s2_carry <= '0;
      v2       <= 1'b0;
    end else if (bus.i_ce) begin
      s2_sum   <= e0s;
      s2_carry <= e0c;
      v2       <= v1;
    end
  end

  // S3: final carry-propagate add, carry out of bit PROD_W-1 dropped
  logic [PROD_W-1:0] prod_q;
  logic              valid_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else if (bus.i_ce) begin
      prod_q  <= s2_sum + s2_carry;
      valid_q <= v2;
    end
  end

  assign bus.o_product = prod_q;
  assign bus.o_valid   = valid_q;

endmodule

// File: tb/tb_pp_reduce_pipe_18x18.sv
// Scoreboard bench for pp_reduce_pipe_18x18. A local radix-4 Booth encoder builds
// the partial products; hand-computed products are queued at issue and popped
// by a monitor whenever a new valid result is loaded at the output.
module tb_pp_reduce_pipe_18x18;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pp_reduce_pipe_18x18_if bus ();

  pp_reduce_pipe_18x18 dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [35:0] exp_q[$];
  logic        mv [3];
  logic [35:0] mp [3];
  logic        new_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Radix-4 Booth encoding of b, multiplicand a; sa/sb select signed operands.
  function automatic logic [9:0][19:0] booth(input logic [17:0] a, input logic [17:0] b,
                                             input logic sa, input logic sb);
    logic [9:0][19:0] r;
    longint           av;
    longint           v;
    logic [19:0]      bx;
    int               prev;
    int               d;
    av   = sa ? longint'($signed(a)) : longint'(a);
    bx   = sb ? {{2{b[17]}}, b} : {2'b00, b};
    prev = 0;
    for (int k = 0; k < 10; k++) begin
      d    = prev + int'(bx[2*k]) - 2 * int'(bx[2*k+1]);
      prev = int'(bx[2*k+1]);
      v    = longint'(d) * av;
      r[k] = v[19:0];
    end
    return r;
  endfunction

  // Weighted sum of the presented partial products, mod 2^36.
  function automatic logic [35:0] ref_sum(input logic [9:0][19:0] p);
    longint s;
    s = 0;
    for (int k = 0; k < 10; k++) begin
      s += longint'($signed(p[k])) <<< (2 * k);
    end
    return s[35:0];
  endfunction

  // Reference pipeline: tracks valid and data the way the output should look.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] <= 1'b0;
        mp[i] <= '0;
      end
      new_out <= 1'b0;
      exp_q.delete();
    end else begin
      new_out <= 1'b0;
      if (bus.i_ce) begin
        mv[2]   <= mv[1];
        mv[1]   <= mv[0];
        mv[0]   <= bus.i_valid;
        mp[2]   <= mp[1];
        mp[1]   <= mp[0];
        mp[0]   <= ref_sum({bus.i_pp10, bus.i_pp9, bus.i_pp8, bus.i_pp7, bus.i_pp6,
                            bus.i_pp5, bus.i_pp4, bus.i_pp3, bus.i_pp2, bus.i_pp1});
        new_out <= mv[1];
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst) begin
      check("o_valid", 64'(bus.o_valid), 64'(mv[2]));
      check("o_product_track", 64'(bus.o_product), 64'(mp[2]));
      if (new_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_empty: got unexpected product 0x%0h expected none", bus.o_product);
        end else begin
          e = exp_q.pop_front();
          check("sb_product", 64'(bus.o_product), 64'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
    bus.i_pp1 = '0; bus.i_pp2 = '0; bus.i_pp3 = '0; bus.i_pp4 = '0; bus.i_pp5  = '0;
    bus.i_pp6 = '0; bus.i_pp7 = '0; bus.i_pp8 = '0; bus.i_pp9 = '0; bus.i_pp10 = '0;
  endtask

  task automatic issue(input logic [17:0] a, input logic [17:0] b, input logic sa,
                       input logic sb, input logic [35:0] exp);
    logic [9:0][19:0] p;
    p = booth(a, b, sa, sb);
    bus.i_valid = 1'b1;
    bus.i_pp1 = p[0]; bus.i_pp2 = p[1]; bus.i_pp3 = p[2]; bus.i_pp4 = p[3]; bus.i_pp5  = p[4];
    bus.i_pp6 = p[5]; bus.i_pp7 = p[6]; bus.i_pp8 = p[7]; bus.i_pp9 = p[8]; bus.i_pp10 = p[9];
    if (bus.i_ce) exp_q.push_back(exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_ce = 1'b1;
    idle();
    repeat (3) tick();
    check("reset_valid", 64'(bus.o_valid), 64'd0);
    check("reset_product", 64'(bus.o_product), 64'd0);
    rst = 1'b0;

    // T1: unsigned full scale
    issue(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0, 36'hF_FFF8_0001);
    tick();
    idle();
    repeat (PIPE_LAT + 1) tick();

    // Back-to-back stream of corner cases
    issue(18'h20000, 18'h20000, 1'b1, 1'b1, 36'h4_0000_0000);   // -2^17 * -2^17
    tick();
    issue(18'h00003, 18'h3FFFB, 1'b1, 1'b1, 36'hF_FFFF_FFF1);   // 3 * -5
    tick();
    issue(18'h1FFFF, 18'h20000, 1'b1, 1'b1, 36'hC_0002_0000);   // max pos * min neg
    tick();
    issue(18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1, 36'hF_FFFC_0001);   // unsigned max * -1
    tick();
    issue(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 36'hF_FFFC_0001);   // -1 * unsigned max
    tick();
    issue(18'h00000, 18'h12345, 1'b1, 1'b1, 36'h0_0000_0000);
    tick();
    issue(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b1, 36'h0_0000_0001);   // -1 * -1
    tick();
    idle();
    repeat (PIPE_LAT + 1) tick();

    // T4: stream with a 2-cycle stall after the second input
    issue(18'd1, 18'd1, 1'b0, 1'b0, 36'd1);
    tick();
    issue(18'd2, 18'd3, 1'b0, 1'b0, 36'd6);
    tick();
    bus.i_ce = 1'b0;
    issue(18'd7, 18'd9, 1'b0, 1'b0, 36'd63);   // ignored while stalled, held by source
    tick();
    tick();
    bus.i_ce = 1'b1;
    issue(18'd7, 18'd9, 1'b0, 1'b0, 36'd63);
    tick();
    idle();
    repeat (PIPE_LAT + 2) tick();

    // T5: reset with one result at the output and two still in flight
    issue(18'd5, 18'd5, 1'b0, 1'b0, 36'd25);
    tick();
    issue(18'd100, 18'd100, 1'b0, 1'b0, 36'd10000);
    tick();
    issue(18'd7, 18'd7, 1'b0, 1'b0, 36'd49);
    tick();
    idle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", 64'(bus.o_valid), 64'd0);
    check("midrst_product", 64'(bus.o_product), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (PIPE_LAT + 3) tick();

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
